song_sequencer: RTL and testbench
=================================

# song_sequencer

Parametrised successor to the fixed 128-entry song ROM. It is a runtime-loadable, multi-song note memory with a built-in playback sequencer. It walks one song's entries, holds each note for its duration counted in beat ticks, and stops at an end marker. It sits between the music controller (play/select/restart) and the tone generator, which consumes `note`.

## Interface
- `NOTE_W`, 6: note code width; code 0 = rest.
- `DUR_W`, 6: duration width, in beats; duration 0 = end-of-song marker.
- `SONG_ADDR_W`, 5: entries per song = 2**SONG_ADDR_W.
- `SEL_W`, 2: number of songs = 2**SEL_W; total depth 2**(SEL_W+SONG_ADDR_W) (128 by default).
- `clk` in 1: the single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `play` in 1: level. A rising edge starts playback from IDLE. Low pauses playback.
- `restart` in 1: pulse. Restarts at index 0 of the current `song_sel`, from any state.
- `song_sel` in SEL_W: song bank, sampled only at start or restart.
- `beat` in 1: one-cycle tempo tick.
- `wr_en` in 1: memory write strobe.
- `wr_addr` in SEL_W+SONG_ADDR_W: write address, {song, index}.
- `wr_data` in NOTE_W+DUR_W: entry {note, duration}.
- `note` out NOTE_W: currently sounding note; 0 when idle or paused.
- `note_start` out 1: one-cycle pulse when a new entry begins sounding.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a song ends.
- `cur_index` out SONG_ADDR_W: index of the entry currently sounding.

## Operation
- Memory: 2**(SEL_W+SONG_ADDR_W) x (NOTE_W+DUR_W).
  - Synchronous write, synchronous read with one-cycle latency.
  - Contents are not reset.
  - A write and a read to the same address in the same cycle: the read returns the old data.
  - Writes are legal in any state.
- States: IDLE, FETCH, LOAD, PLAY, DONE.
- IDLE:
  - A `play` rising edge (registered `play` compared with the current value) latches `song_sel` and sets index=0, then goes to FETCH.
- FETCH:
  - Presents {song, index} to memory; always goes to LOAD next cycle.
- LOAD:
  - If dur≠0: `note`←entry note, remaining←dur, `cur_index`←index, pulse `note_start`, go to PLAY.
  - If dur=0: this is the end of the song; see Configuration.
- PLAY, with `play`=1:
  - Each `beat` decrements remaining.
  - A beat arriving with remaining=1 advances the entry:
    - If index is the last index, treat it as the end of the song.
    - Otherwise index+1, go to FETCH.
- PLAY, with `play`=0:
  - Paused: `note` reads 0, beats are ignored, remaining and index are held.
  - Raising `play` resumes with the same note and remaining count.
- DONE:
  - Pulses `done` for one cycle, clears `note` to 0, returns to IDLE.
- `restart` has priority over every transition: it latches `song_sel`, sets index=0, goes to FETCH. It also works from IDLE.
- Arithmetic: index increments modulo 2**SONG_ADDR_W and never crosses into the next song bank. Remaining is DUR_W bits and never underflows.

## Timing
- Reset: state=IDLE; `note`=0, `note_start`=0, `busy`=0, `done`=0, `cur_index`=0; the internal registered copy of `play` (used for edge detection) =0.
- Start latency: `play` edge at cycle N → FETCH at N+1, LOAD at N+2, `note`/`note_start` valid at N+3.
- Inter-note gap: the 2 cycles of FETCH and LOAD. `note` holds the previous value during the gap, so the output never glitches to 0 between notes.
- Beats arriving in FETCH, LOAD, DONE or IDLE are dropped. The integrator guarantees a beat period of at least 4 cycles.
- A note of duration D sounds for exactly D beats.
- Reset asserted mid-song aborts immediately with no `done` pulse.

## Configuration
- `SONG_SEQ_LOOP_EN`:
  - Defined: an end of song (dur=0 marker, or advancing past the last index) sets index=0 and goes to FETCH, with no `done` pulse. If the marker is at index 0 (empty song), go to DONE instead, to avoid an endless loop.
  - Undefined: every end of song goes to DONE.

## Test plan
- Load song 1 = {(37,2),(42,1),(0,0)}, beat every 8 cycles, pulse `play` → `note` 37 for 2 beats, then 42 for 1 beat, then `done` pulse, `busy`=0, `note`=0.
- Same song, `play` dropped after the first beat of 37, held low 5 beats, then raised → `note`=0 while paused, then 37 resumes for exactly 1 more beat.
- Fill all 32 entries of song 2 with (44,1), no marker → index wraps at 31 into the end-of-song path, never reads song 3; `done` fires without the loop macro.
- With `SONG_SEQ_LOOP_EN`, song 1 from the first test → sequence 37,42,37,42… with no `done`. Empty song (first entry (0,0)) → `done` within 3 cycles.
- `restart` with `song_sel`=3 in the middle of a note → `note_start` 3 cycles later with song 3 entry 0; in-flight beats are dropped.
- `reset_n` low mid-PLAY → all outputs 0 immediately. Memory contents survive: a replay after reset produces the same notes.

Source files
------------

// File: rtl/song_sequencer.sv
// Runtime-loadable multi-song note memory with a beat-driven playback sequencer.
// Optional build macro SONG_SEQ_LOOP_EN: songs loop back to index 0 instead of ending.
module song_sequencer #(
    parameter int unsigned NOTE_W      = 6,
    parameter int unsigned DUR_W       = 6,
    parameter int unsigned SONG_ADDR_W = 5,
    parameter int unsigned SEL_W       = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          play,
    input  logic                          restart,
    input  logic [SEL_W-1:0]              song_sel,
    input  logic                          beat,
    input  logic                          wr_en,
    input  logic [SEL_W+SONG_ADDR_W-1:0]  wr_addr,
    input  logic [NOTE_W+DUR_W-1:0]       wr_data,
    output logic [NOTE_W-1:0]             note,
    output logic                          note_start,
    output logic                          busy,
    output logic                          done,
    output logic [SONG_ADDR_W-1:0]        cur_index
);

    localparam int unsigned ADDR_W = SEL_W + SONG_ADDR_W;
    localparam int unsigned ENT_W  = NOTE_W + DUR_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

`ifdef SONG_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       song_q, song_d;
    logic [SONG_ADDR_W-1:0] idx_q, idx_d;
    logic [DUR_W-1:0]       rem_q, rem_d;
    logic [NOTE_W-1:0]      cur_note_q, cur_note_d;
    logic [NOTE_W-1:0]      note_q, note_d;
    logic                   note_start_q, note_start_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [SONG_ADDR_W-1:0] cur_index_q, cur_index_d;
    logic                   play_q;

    logic [ENT_W-1:0]       mem [DEPTH];
    logic [ENT_W-1:0]       rd_data_q;
    logic [ADDR_W-1:0]      rd_addr_c;
    logic [NOTE_W-1:0]      ld_note_c;
    logic [DUR_W-1:0]       ld_dur_c;
    logic                   last_idx_c;
    logic                   play_rise_c;
    logic                   eos_c;

    assign rd_addr_c   = {song_q, idx_q};
    assign ld_note_c   = rd_data_q[ENT_W-1:DUR_W];
    assign ld_dur_c    = rd_data_q[DUR_W-1:0];
    assign last_idx_c  = (idx_q == {SONG_ADDR_W{1'b1}});
    assign play_rise_c = play & ~play_q;

    // Note memory: unreset contents, read-before-write on address collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr_c];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        song_d       = song_q;
        idx_d        = idx_q;
        rem_d        = rem_q;
        cur_note_d   = cur_note_q;
        note_d       = note_q;
        note_start_d = 1'b0;
        done_d       = 1'b0;
        cur_index_d  = cur_index_q;
        eos_c        = 1'b0;

        case (state_q)
            S_IDLE: begin
                note_d = '0;
                if (play_rise_c) begin
                    song_d  = song_sel;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (ld_dur_c != '0) begin
                    note_d       = ld_note_c;
                    cur_note_d   = ld_note_c;
                    rem_d        = ld_dur_c;
                    cur_index_d  = idx_q;
                    note_start_d = 1'b1;
                    state_d      = S_PLAY;
                end else begin
                    eos_c = 1'b1;
                end
            end
            S_PLAY: begin
                if (play) begin
                    // note keeps the current value through the FETCH/LOAD gap
                    note_d = cur_note_q;
                    if (beat) begin
                        if (rem_q > DUR_W'(1)) begin
                            rem_d = rem_q - DUR_W'(1);
                        end else if (last_idx_c) begin
                            eos_c = 1'b1;
                        end else begin
                            idx_d   = idx_q + SONG_ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end
                end else begin
                    note_d = '0;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                note_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An empty song always ends, otherwise looping would never terminate.
        if (eos_c) begin
            if (LOOP_EN && (idx_q != '0)) begin
                idx_d   = '0;
                state_d = S_FETCH;
            end else begin
                state_d = S_DONE;
            end
        end

        if (restart) begin
            song_d       = song_sel;
            idx_d        = '0;
            rem_d        = rem_q;
            cur_note_d   = cur_note_q;
            cur_index_d  = cur_index_q;
            note_d       = note_q;
            note_start_d = 1'b0;
            done_d       = 1'b0;
            state_d      = S_FETCH;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            song_q       <= '0;
            idx_q        <= '0;
            rem_q        <= '0;
            cur_note_q   <= '0;
            note_q       <= '0;
            note_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cur_index_q  <= '0;
            play_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            song_q       <= song_d;
            idx_q        <= idx_d;
            rem_q        <= rem_d;
            cur_note_q   <= cur_note_d;
            note_q       <= note_d;
            note_start_q <= note_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cur_index_q  <= cur_index_d;
            play_q       <= play;
        end
    end

    assign note       = note_q;
    assign note_start = note_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cur_index  = cur_index_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed self-checking bench for song_sequencer (default build and SONG_SEQ_LOOP_EN build).
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       play;
    logic       restart;
    logic [1:0] song_sel;
    logic       beat;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [11:0] wr_data;
    logic [5:0] note;
    logic       note_start;
    logic       busy;
    logic       done;
    logic [4:0] cur_index;

    int checks = 0;
    int errors = 0;

    song_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .play       (play),
        .restart    (restart),
        .song_sel   (song_sel),
        .beat       (beat),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .note       (note),
        .note_start (note_start),
        .busy       (busy),
        .done       (done),
        .cur_index  (cur_index)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_entry(input logic [1:0] s, input logic [4:0] i,
                               input logic [5:0] n, input logic [5:0] d);
        wr_en   = 1'b1;
        wr_addr = {s, i};
        wr_data = {n, d};
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_beat;
        beat = 1'b1;
        step(1);
        beat = 1'b0;
    endtask

    task automatic apply_reset;
        reset_n = 1'b0;
        play    = 1'b0;
        restart = 1'b0;
        beat    = 1'b0;
        wr_en   = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        play     = 1'b0;
        restart  = 1'b0;
        beat     = 1'b0;
        wr_en    = 1'b0;
        song_sel = 2'd0;
        wr_addr  = '0;
        wr_data  = '0;
        #2;
        checks++;
        if (note !== 6'd0 || note_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cur_index !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: note=%0d ns=%b busy=%b done=%b idx=%0d expected all 0",
                     note, note_start, busy, done, cur_index);
        end
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_basic;
        apply_reset();
        song_sel = 2'd1;
        play     = 1'b1;
        step(1);
        checks++;
        if (busy !== 1'b1 || note !== 6'd0 || note_start !== 1'b0) begin
            errors++;
            $display("FAIL basic_fetch: busy=%b note=%0d ns=%b expected busy=1 note=0 ns=0", busy, note, note_start);
        end
        step(2);
        checks++;
        if (note !== 6'd37 || note_start !== 1'b1 || cur_index !== 5'd0) begin
            errors++;
            $display("FAIL basic_first_note: note=%0d ns=%b idx=%0d expected 37 1 0", note, note_start, cur_index);
        end
        step(1);
        checks++;
        if (note_start !== 1'b0 || note !== 6'd37) begin
            errors++;
            $display("FAIL basic_ns_pulse: ns=%b note=%0d expected 0 37", note_start, note);
        end
        step(6);
        pulse_beat();
        step(7);
        checks++;
        if (note !== 6'd37 || note_start !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_beat1: note=%0d ns=%b expected 37 0", note, note_start);
        end
        pulse_beat();
        checks++;
        if (note !== 6'd37) begin
            errors++;
            $display("FAIL basic_gap_hold: note=%0d expected 37", note);
        end
        step(2);
        checks++;
        if (note !== 6'd42 || note_start !== 1'b1 || cur_index !== 5'd1) begin
            errors++;
            $display("FAIL basic_second_note: note=%0d ns=%b idx=%0d expected 42 1 1", note, note_start, cur_index);
        end
        step(5);
        pulse_beat();
`ifdef SONG_SEQ_LOOP_EN
        step(4);
        checks++;
        if (note !== 6'd37 || note_start !== 1'b1 || cur_index !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_loop_back: note=%0d ns=%b idx=%0d done=%b expected 37 1 0 0",
                     note, note_start, cur_index, done);
        end
`else
        step(2);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || note !== 6'd42) begin
            errors++;
            $display("FAIL basic_done_state: busy=%b done=%b note=%0d expected 1 0 42", busy, done, note);
        end
        step(1);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || note !== 6'd0) begin
            errors++;
            $display("FAIL basic_end: done=%b busy=%b note=%0d expected 1 0 0", done, busy, note);
        end
        step(1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b expected 0", done);
        end
`endif
    endtask

    task automatic test_pause;
        apply_reset();
        song_sel = 2'd1;
        play     = 1'b1;
        step(3);
        checks++;
        if (note !== 6'd37 || note_start !== 1'b1) begin
            errors++;
            $display("FAIL pause_start: note=%0d ns=%b expected 37 1", note, note_start);
        end
        step(4);
        pulse_beat();
        step(2);
        play = 1'b0;
        step(1);
        checks++;
        if (note !== 6'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pause_enter: note=%0d busy=%b expected 0 1", note, busy);
        end
        for (int b = 0; b < 5; b++) begin
            step(7);
            pulse_beat();
            checks++;
            if (note !== 6'd0 || busy !== 1'b1 || note_start !== 1'b0) begin
                errors++;
                $display("FAIL pause_beat%0d: note=%0d busy=%b ns=%b expected 0 1 0", b, note, busy, note_start);
            end
        end
        step(3);
        play = 1'b1;
        step(1);
        checks++;
        if (note !== 6'd37 || note_start !== 1'b0 || cur_index !== 5'd0) begin
            errors++;
            $display("FAIL pause_resume: note=%0d ns=%b idx=%0d expected 37 0 0", note, note_start, cur_index);
        end
        step(5);
        checks++;
        if (note !== 6'd37) begin
            errors++;
            $display("FAIL pause_hold: note=%0d expected 37", note);
        end
        pulse_beat();
        step(2);
        checks++;
        if (note !== 6'd42 || note_start !== 1'b1 || cur_index !== 5'd1) begin
            errors++;
            $display("FAIL pause_one_more_beat: note=%0d ns=%b idx=%0d expected 42 1 1", note, note_start, cur_index);
        end
    endtask

`ifndef SONG_SEQ_LOOP_EN
    task automatic test_wrap;
        bit found;
        for (int i = 0; i < 32; i++) begin
            write_entry(2'd2, 5'(i), 6'd44, 6'd1);
        end
        apply_reset();
        song_sel = 2'd2;
        play     = 1'b1;
        for (int i = 0; i < 32; i++) begin
            found = 1'b0;
            for (int k = 0; k < 8 && !found; k++) begin
                step(1);
                if (note_start === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found || note !== 6'd44 || cur_index !== 5'(i)) begin
                errors++;
                $display("FAIL wrap_entry%0d: seen=%b note=%0d idx=%0d expected 1 44 %0d",
                         i, found, note, cur_index, i);
            end
            pulse_beat();
        end
        step(1);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || note !== 6'd0) begin
            errors++;
            $display("FAIL wrap_done: done=%b busy=%b note=%0d expected 1 0 0", done, busy, note);
        end
    endtask
`endif

    task automatic test_restart;
        apply_reset();
        song_sel = 2'd1;
        play     = 1'b1;
        step(3);
        step(3);
        song_sel = 2'd3;
        restart  = 1'b1;
        beat     = 1'b1;
        step(1);
        restart  = 1'b0;
        beat     = 1'b0;
        checks++;
        if (note !== 6'd37 || note_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_hold: note=%0d ns=%b busy=%b expected 37 0 1", note, note_start, busy);
        end
        step(2);
        checks++;
        if (note !== 6'd50 || note_start !== 1'b1 || cur_index !== 5'd0) begin
            errors++;
            $display("FAIL restart_note: note=%0d ns=%b idx=%0d expected 50 1 0", note, note_start, cur_index);
        end
        step(5);
        pulse_beat();
        step(7);
        pulse_beat();
        step(7);
        checks++;
        if (note !== 6'd50 || note_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_dur: note=%0d ns=%b busy=%b expected 50 0 1", note, note_start, busy);
        end
        pulse_beat();
`ifdef SONG_SEQ_LOOP_EN
        step(4);
        checks++;
        if (note !== 6'd50 || note_start !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_loop: note=%0d ns=%b done=%b expected 50 1 0", note, note_start, done);
        end
`else
        step(3);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_end: done=%b busy=%b expected 1 0", done, busy);
        end
`endif
    endtask

    task automatic test_reset_mid;
        apply_reset();
        song_sel = 2'd1;
        play     = 1'b1;
        step(3);
        pulse_beat();
        step(3);
        pulse_beat();
        step(2);
        checks++;
        if (note !== 6'd42 || cur_index !== 5'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: note=%0d idx=%0d busy=%b expected 42 1 1", note, cur_index, busy);
        end
        step(2);
        reset_n = 1'b0;
        #1;
        checks++;
        if (note !== 6'd0 || cur_index !== 5'd0 || busy !== 1'b0 || note_start !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: note=%0d idx=%0d busy=%b ns=%b done=%b expected all 0",
                     note, cur_index, busy, note_start, done);
        end
        play = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        play = 1'b1;
        step(3);
        checks++;
        if (note !== 6'd37 || note_start !== 1'b1 || cur_index !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_replay: note=%0d ns=%b idx=%0d expected 37 1 0", note, note_start, cur_index);
        end
    endtask

`ifdef SONG_SEQ_LOOP_EN
    task automatic test_loop;
        bit found;
        bit done_seen;
        logic [5:0] exp_note [5];
        exp_note[0] = 6'd37;
        exp_note[1] = 6'd42;
        exp_note[2] = 6'd37;
        exp_note[3] = 6'd42;
        exp_note[4] = 6'd37;
        done_seen = 1'b0;
        apply_reset();
        song_sel = 2'd1;
        play     = 1'b1;
        for (int n = 0; n < 5; n++) begin
            found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                step(1);
                if (done === 1'b1) done_seen = 1'b1;
                if (note_start === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found || note !== exp_note[n] || done_seen) begin
                errors++;
                $display("FAIL loop_note%0d: seen=%b note=%0d done_seen=%b expected 1 %0d 0",
                         n, found, note, done_seen, exp_note[n]);
            end
            if (exp_note[n] == 6'd37) begin
                step(3);
                pulse_beat();
            end
            step(3);
            pulse_beat();
        end
        song_sel = 2'd0;
        restart  = 1'b1;
        step(1);
        restart  = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            step(1);
            if (done === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || busy !== 1'b0) begin
            errors++;
            $display("FAIL loop_empty_done: seen=%b busy=%b expected 1 0", found, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        write_entry(2'd1, 5'd0, 6'd37, 6'd2);
        write_entry(2'd1, 5'd1, 6'd42, 6'd1);
        write_entry(2'd1, 5'd2, 6'd0,  6'd0);
        write_entry(2'd3, 5'd0, 6'd50, 6'd3);
        write_entry(2'd3, 5'd1, 6'd0,  6'd0);
        write_entry(2'd0, 5'd0, 6'd0,  6'd0);
        test_basic();
        test_pause();
`ifndef SONG_SEQ_LOOP_EN
        test_wrap();
`endif
        test_restart();
        test_reset_mid();
`ifdef SONG_SEQ_LOOP_EN
        test_loop();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
